clock_disp_scan: RTL and testbench

Multiplexed six-digit seven-segment display driver for the digital clock, placed directly downstream of the BCD time counter. Each frame it snapshots the six time digits (hh:mm:ss), scans them one digit at a time onto a shared segment bus with a one-hot digit enable, and inserts a short ghost-blanking gap at each digit change. It also generates a blinking colon on the decimal points and flags invalid digits.

---
 rtl/clock_disp_pkg.sv | 30 +++
 rtl/clock_disp_scan_bcd_to_7seg.sv | 27 ++
 rtl/clock_disp_scan.sv | 177 +++++++++++++++++
 tb/tb_clock_disp_scan.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scanner: digit count, digit indices
// and active-high seven-segment patterns (bit0 = a ... bit6 = g).
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] IDX_LS_SEC = 3'd0;
  localparam logic [2:0] IDX_MS_SEC = 3'd1;
  localparam logic [2:0] IDX_LS_MIN = 3'd2;
  localparam logic [2:0] IDX_MS_MIN = 3'd3;
  localparam logic [2:0] IDX_LS_HR  = 3'd4;
  localparam logic [2:0] IDX_MS_HR  = 3'd5;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Any non-BCD code decodes to a dash; used to force invalid hours.
  localparam logic [3:0] BCD_DASH = 4'hF;

endpackage

// File: rtl/clock_disp_scan_bcd_to_7seg.sv
// Combinational BCD to active-high seven-segment decoder; codes above 9
// show a dash.
module bcd_to_7seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot, ghost
// gap and blinking colon. Define CLOCK_DISP_12H_EN for 12-hour display with pm.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int GHOST_GAP   = 2,
  parameter int BLINK_DIV   = 50_000_000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic [3:0] ms_min,
  input  logic [3:0] ls_min,
  input  logic [3:0] ms_sec,
  input  logic [3:0] ls_sec,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       pm,
  output logic       frame_start
);

  localparam int   CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int   BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [BLK_W-1:0] r_blink;
  logic             r_colon;
  logic [3:0]       r_sh_dig [NUM_DIGITS];
  logic             r_sh_blank;
  logic             r_sh_pm;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [5:0]       r_an;
  logic             r_pm;
  logic             r_frame_start;

  logic [7:0] w_hour;
  logic       w_hr_bad;
  logic [3:0] w_hr_tens;
  logic [3:0] w_hr_ones;
  logic       w_hr_pm;
  logic       w_hr_blank;
`ifdef CLOCK_DISP_12H_EN
  logic [7:0] w_h12;
`endif

  // Hour conversion runs on the live inputs and is captured with the snapshot.
  always_comb begin
    w_hour     = 8'(ms_hr) * 8'd10 + 8'(ls_hr);
    w_hr_bad   = (ms_hr > 4'd9) || (ls_hr > 4'd9) || (w_hour > 8'd23);
`ifdef CLOCK_DISP_12H_EN
    if (w_hour == 8'd0)
      w_h12 = 8'd12;
    else if (w_hour > 8'd12)
      w_h12 = w_hour - 8'd12;
    else
      w_h12 = w_hour;
    w_hr_pm    = (w_hour >= 8'd12);
    w_hr_tens  = (w_h12 >= 8'd10) ? 4'd1 : 4'd0;
    w_hr_ones  = (w_h12 >= 8'd10) ? 4'(w_h12 - 8'd10) : 4'(w_h12);
    w_hr_blank = (w_h12 < 8'd10);
`else
    w_hr_pm    = 1'b0;
    w_hr_tens  = ms_hr;
    w_hr_ones  = ls_hr;
    w_hr_blank = 1'b0;
`endif
    if (w_hr_bad) begin
      w_hr_tens  = BCD_DASH;
      w_hr_ones  = BCD_DASH;
      w_hr_pm    = 1'b0;
      w_hr_blank = 1'b0;
    end
  end

  logic       w_snap;
  logic       w_gap;
  logic [3:0] w_digit;
  logic [6:0] w_dec;
  logic [6:0] w_seg_act;
  logic [5:0] w_an_act;
  logic       w_dp_act;

  assign w_snap = (r_cnt == '0) && (r_idx == 3'd0);
  assign w_gap  = (r_cnt < CNT_W'(GHOST_GAP));

  always_comb begin
    w_digit = BCD_DASH;
    case (r_idx)
      3'd0: w_digit = r_sh_dig[0];
      3'd1: w_digit = r_sh_dig[1];
      3'd2: w_digit = r_sh_dig[2];
      3'd3: w_digit = r_sh_dig[3];
      3'd4: w_digit = r_sh_dig[4];
      3'd5: w_digit = r_sh_dig[5];
      default: w_digit = BCD_DASH;
    endcase
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_comb begin
    w_an_act  = 6'b000000;
    w_seg_act = SEG_OFF;
    w_dp_act  = 1'b0;
    if (!w_gap) begin
      w_an_act  = 6'b000001 << r_idx;
      w_seg_act = (r_idx == IDX_MS_HR && r_sh_blank) ? SEG_OFF : w_dec;
      w_dp_act  = r_colon && (r_idx == IDX_LS_HR || r_idx == IDX_LS_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_blink       <= '0;
      r_colon       <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_sh_dig[i] <= 4'd0;
      r_sh_blank    <= 1'b0;
      r_sh_pm       <= 1'b0;
      r_seg         <= {7{POL}};
      r_dp          <= POL;
      r_an          <= {6{POL}};
      r_pm          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Colon timebase is free-running and independent of the scan.
      if (r_blink == BLK_W'(BLINK_DIV - 1)) begin
        r_blink <= '0;
        r_colon <= ~r_colon;
      end else begin
        r_blink <= r_blink + BLK_W'(1);
      end

      r_frame_start <= w_snap;
      if (w_snap) begin
        r_sh_dig[0] <= ls_sec;
        r_sh_dig[1] <= ms_sec;
        r_sh_dig[2] <= ls_min;
        r_sh_dig[3] <= ms_min;
        r_sh_dig[4] <= w_hr_ones;
        r_sh_dig[5] <= w_hr_tens;
        r_sh_blank  <= w_hr_blank;
        r_sh_pm     <= w_hr_pm;
      end

      r_an  <= {6{POL}} ^ w_an_act;
      r_seg <= {7{POL}} ^ w_seg_act;
      r_dp  <= POL ^ w_dp_act;
      r_pm  <= r_sh_pm;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign pm          = r_pm;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Bench for clock_disp_scan: directed time vectors, per-cycle expected display
// words queued by the driver and compared by an independent monitor.
module tb_clock_disp_scan;

  localparam int RD = 4;
  localparam int GG = 1;
  localparam int BD = 8;
  localparam int FRAME = 6 * RD;
  localparam int W = 17;  // {pm_chk, pm, fs, dp, an[5:0], seg[6:0]}

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S9 = 7'h6F;
  localparam logic [6:0] SD = 7'h40, SB = 7'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ms_hr = 0, ls_hr = 0, ms_min = 0, ls_min = 0, ms_sec = 0, ls_sec = 0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       pm;
  logic       frame_start;

  clock_disp_scan #(
    .REFRESH_DIV (RD),
    .GHOST_GAP   (GG),
    .BLINK_DIV   (BD),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ms_hr       (ms_hr),
    .ls_hr       (ls_hr),
    .ms_min      (ms_min),
    .ls_min      (ls_min),
    .ms_sec      (ms_sec),
    .ls_sec      (ls_sec),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .pm          (pm),
    .frame_start (frame_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic mon_en = 1'b0;
  int   g = 0;  // output cycle index since the last reset edge

  // vectors: inputs in digit-index order {ls_sec, ms_sec, ls_min, ms_min, ls_hr, ms_hr}
  logic [3:0] vin [7][6];
  logic [6:0] vseg[7][6];
  logic       vpm [7];

  initial begin
    vin[0] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};  // 12:34:56
    vin[1] = '{4'd7, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};  // 12:34:57
    vin[2] = '{4'd6, 4'd5, 4'hA, 4'd3, 4'd2, 4'd1};  // 12:3A:56
    vin[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd2};  // 25:00:00
    vin[4] = '{4'd0, 4'd0, 4'd5, 4'd0, 4'd3, 4'd1};  // 13:05:00
    vin[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};  // 00:00:00
    vin[6] = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};  // 23:59:59
    vseg[0] = '{S6, S5, S4, S3, S2, S1};
    vseg[1] = '{S7, S5, S4, S3, S2, S1};
    vseg[2] = '{S6, S5, SD, S3, S2, S1};
    vseg[3] = '{S0, S0, S0, S0, SD, SD};
`ifdef CLOCK_DISP_12H_EN
    vseg[4] = '{S0, S0, S5, S0, S1, SB};
    vseg[5] = '{S0, S0, S0, S0, S2, S1};
    vseg[6] = '{S9, S5, S9, S5, S1, S1};
    vpm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    vseg[4] = '{S0, S0, S5, S0, S3, S1};
    vseg[5] = '{S0, S0, S0, S0, S0, S0};
    vseg[6] = '{S9, S5, S9, S5, S3, S2};
    vpm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
  end

  // driver tasks
  task automatic set_inputs(input int v);
    ls_sec = vin[v][0]; ms_sec = vin[v][1]; ls_min = vin[v][2];
    ms_min = vin[v][3]; ls_hr  = vin[v][4]; ms_hr  = vin[v][5];
  endtask

  task automatic push_frame(input int v);
    int j, c, idx;
    logic col, gap;
    logic [5:0] one;
    logic [W-1:0] e;
    for (int k = 0; k < FRAME; k++) begin
      j   = g + k;
      c   = j % RD;
      idx = (j % FRAME) / RD;
      col = ((j / BD) % 2) == 1;
      gap = (c < GG);
      one = 6'b000001 << idx;
      e[16]   = (c != 0);
      e[15]   = vpm[v];
      e[14]   = ((j % FRAME) == 0);
      e[13]   = gap ? 1'b1 : ~(col && (idx == 2 || idx == 4));
      e[12:7] = gap ? 6'h3F : ~one;
      e[6:0]  = gap ? 7'h7F : ~vseg[v][idx];
      exp_q.push_back(e);
    end
    g += FRAME;
  endtask

  task automatic run_frame(input int v, input int change_at, input int v2);
    set_inputs(v);
    push_frame(v);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k + 1 == change_at) set_inputs(v2);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_an"}, 32'(an), 32'h3F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_pm"}, 32'(pm), 32'h0);
    check({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // scoreboard monitor
  logic [W-1:0] mon_e, mon_a;
  int mon_n = 0;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL scan_underflow: got output cycle %0d expected none pending", mon_n);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = {mon_e[16], pm, frame_start, dp, an, seg};
        if (!mon_e[16]) begin
          mon_e[15] = 1'b0;
          mon_a[15] = 1'b0;
        end
        if (mon_a === mon_e) n_pass++;
        else $display("FAIL scan_cycle_%0d: got pm/fs/dp/an/seg %b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                      mon_n, mon_a[15], mon_a[14], mon_a[13], mon_a[12:7], mon_a[6:0],
                      mon_e[15], mon_e[14], mon_e[13], mon_e[12:7], mon_e[6:0]);
      end
      mon_n++;
    end
  end

  // main sequence
  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset("reset");

    @(negedge clk);
    rst = 1'b0; g = 0; mon_en = 1'b1;
    run_frame(0, 10, 1);   // inputs move to :57 mid-frame; display holds :56
    run_frame(1, 0, 1);
    for (int v = 2; v < 7; v++) run_frame(v, 0, v);
    mon_en = 1'b0;
    check("queue_drain_1", 32'(exp_q.size()), 32'd0);

    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset("mid_reset");

    @(negedge clk);
    rst = 1'b0; g = 0; mon_en = 1'b1;
    exp_q.delete();
    run_frame(0, 0, 0);
    mon_en = 1'b0;
    check("queue_drain_2", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
